// File: rtl/vga_pxl_addr_gen_if.sv
// VGA output bundle from the address generator to the display side.
// frame_start exists only when VGA_FRAME_START_EN is defined.
interface vga_pxl_addr_gen_if;
  logic [13:0] pxl_addr;
  logic        hsync;
  logic        vsync;
  logic        disp_en;
`ifdef VGA_FRAME_START_EN
  logic        frame_start;

  modport master (output pxl_addr, hsync, vsync, disp_en, frame_start);
  modport slave  (input  pxl_addr, hsync, vsync, disp_en, frame_start);
`else
  modport master (output pxl_addr, hsync, vsync, disp_en);
  modport slave  (input  pxl_addr, hsync, vsync, disp_en);
`endif
endinterface

// File: rtl/vga_pxl_addr_gen.sv
// 640x480@60 VGA timing plus 128x96 (5x upscaled) framebuffer address generator.
// Optional macro VGA_FRAME_START_EN adds a one-clk frame_start pulse aligned with the syncs.
module vga_pxl_addr_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned SCALE   = 5
) (
  input logic                clk,
  input logic                reset,
  vga_pxl_addr_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HVis     = HW'(H_VIS);
  localparam logic [HW-1:0] HSyncBeg = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VLast    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VVis     = VW'(V_VIS);
  localparam logic [VW-1:0] VSyncBeg = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0] SubLast  = SW'(SCALE - 1);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [6:0]    col_q, col_d, row_q, row_d;
  logic [SW-1:0] col_sub_q, col_sub_d, row_sub_q, row_sub_d;
  logic [13:0]   addr_q, addr_d;
  logic          hsync_q, vsync_q, disp_en_q;
  logic          tick, h_wrap, v_wrap, vis_d;

  assign tick   = (div_q == DivLast);
  assign h_wrap = (hcnt_q == HLast);
  assign v_wrap = (vcnt_q == VLast);

  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    col_d     = col_q;
    row_d     = row_q;
    col_sub_d = col_sub_q;
    row_sub_d = row_sub_q;
    if (tick) begin
      if (h_wrap) begin
        hcnt_d    = '0;
        col_d     = '0;
        col_sub_d = '0;
        if (v_wrap) begin
          vcnt_d    = '0;
          row_d     = '0;
          row_sub_d = '0;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
          if (vcnt_q < VVis) begin
            if (row_sub_q == SubLast) begin
              row_sub_d = '0;
              row_d     = row_q + 1'b1;
            end else begin
              row_sub_d = row_sub_q + 1'b1;
            end
          end
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q < HVis) begin
          if (col_sub_q == SubLast) begin
            col_sub_d = '0;
            col_d     = col_q + 1'b1;
          end else begin
            col_sub_d = col_sub_q + 1'b1;
          end
        end
      end
    end
    // Address reflects the position being entered, so BRAM data lands with the delayed syncs.
    vis_d  = (hcnt_d < HVis) && (vcnt_d < VVis);
    addr_d = addr_q;
    if (tick) begin
      addr_d = vis_d ? {row_d, col_d} : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      col_sub_q <= '0;
      row_sub_q <= '0;
      addr_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      disp_en_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      col_sub_q <= col_sub_d;
      row_sub_q <= row_sub_d;
      addr_q    <= addr_d;
      hsync_q   <= !((hcnt_q >= HSyncBeg) && (hcnt_q <= HSyncEnd));
      vsync_q   <= !((vcnt_q >= VSyncBeg) && (vcnt_q <= VSyncEnd));
      disp_en_q <= (hcnt_q < HVis) && (vcnt_q < VVis);
    end
  end

  assign vga.pxl_addr = addr_q;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.disp_en  = disp_en_q;

`ifdef VGA_FRAME_START_EN
  logic frame_start_q;

  // div_q == 0 marks the first clk spent at the origin pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= (hcnt_q == '0) && (vcnt_q == '0) && (div_q == '0);
    end
  end

  assign vga.frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_pxl_addr_gen.sv
// Bench: full-size instance for line timing, shrunken-timing instance for whole frames.
module tb_vga_pxl_addr_gen;

  typedef struct packed {
    longint cdiv; longint hvis; longint hfp; longint hsw; longint hbp;
    longint vvis; longint vfp; longint vsw; longint vbp; longint scale;
  } tim_t;

  localparam tim_t TD = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 5};
  localparam tim_t TS = '{2, 20, 3, 4, 3, 15, 2, 2, 3, 5};

  logic   clk   = 1'b0;
  logic   rst   = 1'b1;
  logic   rst_s = 1'b1;
  longint kd    = 0;
  longint ks    = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  vga_pxl_addr_gen_if vd ();
  vga_pxl_addr_gen_if vsm ();

  vga_pxl_addr_gen dut (.clk(clk), .reset(rst), .vga(vd));

  vga_pxl_addr_gen #(
    .CLK_DIV(2), .H_VIS(20), .H_FP(3), .H_SYNC(4), .H_BP(3),
    .V_VIS(15), .V_FP(2), .V_SYNC(2), .V_BP(3), .SCALE(5)
  ) dut_s (.clk(clk), .reset(rst_s), .vga(vsm));

  always #5 clk = ~clk;

  // Clock edges seen since the last reset release.
  always @(posedge clk or posedge rst) if (rst) kd <= 0; else kd <= kd + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) ks <= 0; else ks <= ks + 1;

  function automatic void pos(input tim_t t, input longint k, output longint h, output longint v);
    longint ht, vt, p;
    ht = t.hvis + t.hfp + t.hsw + t.hbp;
    vt = t.vvis + t.vfp + t.vsw + t.vbp;
    p  = (k / t.cdiv) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
  endfunction

  function automatic void model(input tim_t t, input longint k, output logic [16:0] e,
                                output logic fs);
    longint h, v, hp, vp;
    logic [13:0] a;
    logic hs, vs, de;
    pos(t, k, h, v);
    a  = 14'd0;
    hs = 1'b1;
    vs = 1'b1;
    de = 1'b0;
    fs = 1'b0;
    if (h < t.hvis && v < t.vvis) a = 14'((v / t.scale) * 128 + (h / t.scale));
    if (k > 0) begin
      pos(t, k - 1, hp, vp);
      de = (hp < t.hvis) && (vp < t.vvis);
      hs = !(hp >= t.hvis + t.hfp && hp < t.hvis + t.hfp + t.hsw);
      vs = !(vp >= t.vvis + t.vfp && vp < t.vvis + t.vfp + t.vsw);
      fs = (hp == 0) && (vp == 0) && ((k - 1) % t.cdiv == 0);
    end
    e = {a, hs, vs, de};
  endfunction

  task automatic test_reset();
    logic [16:0] got, exp;
    logic fs;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {vd.pxl_addr, vd.hsync, vd.vsync, vd.disp_en};
      n_cmp++;
      if (got !== 17'h00006) begin
        n_bad++;
        $display("FAIL reset_hold: got %h want %h", got, 17'h00006);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      model(TD, kd, exp, fs);
      got = {vd.pxl_addr, vd.hsync, vd.vsync, vd.disp_en};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_release k=%0d: got %h want %h", kd, got, exp);
      end
    end
    repeat ($urandom_range(500, 3000)) @(negedge clk);
    rst = 1'b1;
    #1;
    got = {vd.pxl_addr, vd.hsync, vd.vsync, vd.disp_en};
    n_cmp++;
    if (got !== 17'h00006) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", got, 17'h00006);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      model(TD, kd, exp, fs);
      got = {vd.pxl_addr, vd.hsync, vd.vsync, vd.disp_en};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_restart k=%0d: got %h want %h", kd, got, exp);
      end
    end
  endtask

  task automatic test_lines();
    logic [16:0] got, exp;
    logic fs;
    logic hs_prev = 1'b1;
    int   hs_low  = 0;
    while (kd < 6 * 3200 + 8) begin
      @(negedge clk);
      model(TD, kd, exp, fs);
      got = {vd.pxl_addr, vd.hsync, vd.vsync, vd.disp_en};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL line_model k=%0d: got %h want %h", kd, got, exp);
      end
      if (kd == 16 || kd == 20 || kd == 2556 || kd == 2560 || kd == 16000) begin
        exp[16:3] = (kd == 20) ? 14'd1 : (kd == 2556) ? 14'd127 : (kd == 16000) ? 14'd128 : 14'd0;
        n_cmp++;
        if (vd.pxl_addr !== exp[16:3]) begin
          n_bad++;
          $display("FAIL line_addr k=%0d: got %0d want %0d", kd, vd.pxl_addr, exp[16:3]);
        end
      end
      if (kd == 2560 || kd == 2561) begin
        n_cmp++;
        if (vd.disp_en !== (kd == 2560)) begin
          n_bad++;
          $display("FAIL disp_en_fall k=%0d: got %b want %b", kd, vd.disp_en, kd == 2560);
        end
      end
      if (!vd.hsync) begin
        hs_low++;
      end else if (hs_low != 0) begin
        n_cmp++;
        if (hs_low != 384) begin
          n_bad++;
          $display("FAIL hsync_width: got %0d want 384", hs_low);
        end
        hs_low = 0;
      end
      if (hs_prev && !vd.hsync) begin
        n_cmp++;
        if (kd % 3200 != 2625) begin
          n_bad++;
          $display("FAIL hsync_start: got %0d want 2625", kd % 3200);
        end
      end
      hs_prev = vd.hsync;
    end
  endtask

  task automatic test_small_frames();
    logic [16:0] got, exp;
    logic   fs;
    logic   vs_prev  = 1'b1;
    int     vs_low   = 0;
    int     fs_cnt   = 0;
    longint last_vf  = 0;
    longint last_fs  = 0;
    logic [13:0] amax = 14'd0;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    while (ks < 3950) begin
      @(negedge clk);
      model(TS, ks, exp, fs);
      got = {vsm.pxl_addr, vsm.hsync, vsm.vsync, vsm.disp_en};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL frame_model k=%0d: got %h want %h", ks, got, exp);
      end
      if (vsm.pxl_addr > amax) amax = vsm.pxl_addr;
      if (!vsm.vsync) begin
        vs_low++;
      end else if (vs_low != 0) begin
        n_cmp++;
        if (vs_low != 120) begin
          n_bad++;
          $display("FAIL vsync_width: got %0d want 120", vs_low);
        end
        vs_low = 0;
      end
      if (vs_prev && !vsm.vsync) begin
        if (last_vf != 0) begin
          n_cmp++;
          if (ks - last_vf != 1320) begin
            n_bad++;
            $display("FAIL vsync_period: got %0d want 1320", ks - last_vf);
          end
        end
        last_vf = ks;
      end
      vs_prev = vsm.vsync;
`ifdef VGA_FRAME_START_EN
      n_cmp++;
      if (vsm.frame_start !== fs) begin
        n_bad++;
        $display("FAIL frame_start k=%0d: got %b want %b", ks, vsm.frame_start, fs);
      end
      if (vsm.frame_start === 1'b1) begin
        if (fs_cnt != 0) begin
          n_cmp++;
          if (ks - last_fs != 1320) begin
            n_bad++;
            $display("FAIL frame_start_period: got %0d want 1320", ks - last_fs);
          end
        end
        fs_cnt++;
        last_fs = ks;
      end
`endif
    end
    n_cmp++;
    if (amax !== 14'd259) begin
      n_bad++;
      $display("FAIL addr_max: got %0d want 259", amax);
    end
`ifdef VGA_FRAME_START_EN
    n_cmp++;
    if (fs_cnt != 3) begin
      n_bad++;
      $display("FAIL frame_start_count: got %0d want 3", fs_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, exp;
    logic fs;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(50, 1400)) begin
        @(negedge clk);
        model(TS, ks, exp, fs);
        got = {vsm.pxl_addr, vsm.hsync, vsm.vsync, vsm.disp_en};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL b2b_model k=%0d: got %h want %h", ks, got, exp);
        end
      end
      rst_s = 1'b1;
      #1;
      got = {vsm.pxl_addr, vsm.hsync, vsm.vsync, vsm.disp_en};
      n_cmp++;
      if (got !== 17'h00006) begin
        n_bad++;
        $display("FAIL b2b_reset: got %h want %h", got, 17'h00006);
      end
`ifdef VGA_FRAME_START_EN
      n_cmp++;
      if (vsm.frame_start !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_reset_fs: got %b want 0", vsm.frame_start);
      end
`endif
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_s = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_small_frames();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
